time_set_ctrl: RTL and testbench

- User-input front end that drives the clock core's load interface (load, addrs, data_in) from four raw push-buttons.
- Debounces the buttons, lets the user edit hours, minutes and seconds with wrap-around, then commits all three fields to the clock core as a burst of three one-cycle load writes.
- Sits between the board buttons and the clock top level, in the same 100 MHz domain.

---
 rtl/time_set_ctrl.sv | 174 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Push-button front end for the clock core: synchronises and debounces four buttons,
// edits hours/minutes/seconds with wrap-around, and commits them as three load writes.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic       load,
    output logic [1:0] addrs,
    output logic [5:0] data_out,
    output logic       edit_active,
    output logic [1:0] field_sel,
    output logic [5:0] field_val
);

    typedef enum logic [2:0] {IDLE, EDIT, WR_H, WR_M, WR_S} state_t;

    localparam logic [1:0] F_SEC = 2'b00;
    localparam logic [1:0] F_MIN = 2'b01;
    localparam logic [1:0] F_HR  = 2'b10;
    localparam int B_SET  = 3;
    localparam int B_NEXT = 2;
    localparam int B_INC  = 1;
    localparam int B_DEC  = 0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       raw;
    logic [3:0]       sync1, sync2, deb, deb_q, press;
    logic [CNT_W-1:0] cnt [4];

    assign raw = {btn_set, btn_next, btn_inc, btn_dec};

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values and the synchroniser stages really do delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            press <= '0;
            // NOTE: the counter array is plain flops, not RAM, so it is reset with everything else.
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            press <= deb & ~deb_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only the highest-priority pulse of a cycle acts; the rest are dropped.
    logic do_set, do_next, do_inc, do_dec;
    assign do_set  = press[B_SET];
    assign do_next = press[B_NEXT] & ~press[B_SET];
    assign do_inc  = press[B_INC]  & ~|press[B_SET:B_NEXT];
    assign do_dec  = press[B_DEC]  & ~|press[B_SET:B_INC];

    state_t     state, state_next;
    logic [5:0] hours, minutes, seconds;
    logic [5:0] hours_next, minutes_next, seconds_next;
    logic [1:0] field_sel_next, addrs_next;
    logic [5:0] data_next;
    logic       load_next;
    logic [5:0] sel_max, step_val;

    always_comb begin
        case (field_sel)
            F_HR:    field_val = hours;
            F_MIN:   field_val = minutes;
            default: field_val = seconds;
        endcase
    end

    assign sel_max  = (field_sel == F_HR) ? 6'd23 : 6'd59;
    assign step_val = do_inc ? ((field_val >= sel_max) ? 6'd0 : field_val + 6'd1)
                             : ((field_val == 6'd0) ? sel_max : field_val - 6'd1);

    assign edit_active = (state != IDLE);

    // NOTE: every output of this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        field_sel_next = field_sel;
        hours_next     = hours;
        minutes_next   = minutes;
        seconds_next   = seconds;
        load_next      = 1'b0;
        addrs_next     = addrs;
        data_next      = data_out;
        case (state)
            IDLE: begin
                if (do_set) begin
                    state_next     = EDIT;
                    field_sel_next = F_HR;
                end
            end
            EDIT: begin
                if (do_set) begin
                    state_next = WR_H;
                    load_next  = 1'b1;
                    addrs_next = F_HR;
                    data_next  = hours;
                end else if (do_next) begin
                    case (field_sel)
                        F_HR:    field_sel_next = F_MIN;
                        F_MIN:   field_sel_next = F_SEC;
                        default: field_sel_next = F_HR;
                    endcase
                end else if (do_inc || do_dec) begin
                    case (field_sel)
                        F_HR:    hours_next   = step_val;
                        F_MIN:   minutes_next = step_val;
                        default: seconds_next = step_val;
                    endcase
                end
            end
            // Strobe values are set up one state early because the outputs are registered.
            WR_H: begin
                state_next = WR_M;
                load_next  = 1'b1;
                addrs_next = F_MIN;
                data_next  = minutes;
            end
            WR_M: begin
                state_next = WR_S;
                load_next  = 1'b1;
                addrs_next = F_SEC;
                data_next  = seconds;
            end
            WR_S:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            field_sel <= F_HR;
            hours     <= '0;
            minutes   <= '0;
            seconds   <= '0;
            load      <= 1'b0;
            addrs     <= F_SEC;
            data_out  <= '0;
        end else begin
            state     <= state_next;
            field_sel <= field_sel_next;
            hours     <= hours_next;
            minutes   <= minutes_next;
            seconds   <= seconds_next;
            load      <= load_next;
            addrs     <= addrs_next;
            data_out  <= data_next;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a short debounce window: a vector table of
// button presses plus hand-written sequences for wrap, bounce, commit burst and reset.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_set = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic       load, edit_active;
    logic [1:0] addrs, field_sel;
    logic [5:0] data_out, field_val;

    time_set_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .btn_set(btn_set), .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .load(load), .addrs(addrs), .data_out(data_out),
        .edit_active(edit_active), .field_sel(field_sel), .field_val(field_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] btns;   // {set, next, inc, dec}
        logic       edit;
        logic [1:0] sel;
        logic [5:0] val;
    } vec_t;

    vec_t vecs [9];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge, away from the sampling edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] m);
        {btn_set, btn_next, btn_inc, btn_dec} = m;
    endtask

    task automatic press(input logic [3:0] m);
        drive(m);
        cycles(10);
        drive(4'b0000);
        cycles(10);
    endtask

    task automatic press_n(input logic [3:0] m, input int n);
        for (int i = 0; i < n; i++) press(m);
    endtask

    initial begin
        int         lc, first, last, k;
        logic [1:0] la [3];
        logic [5:0] ld [3];

        vecs[0] = '{"idle_inc",      4'b0010, 1'b0, 2'b10, 6'd0};
        vecs[1] = '{"idle_next",     4'b0100, 1'b0, 2'b10, 6'd0};
        vecs[2] = '{"enter_edit",    4'b1000, 1'b1, 2'b10, 6'd0};
        vecs[3] = '{"hr_dec_wrap",   4'b0001, 1'b1, 2'b10, 6'd23};
        vecs[4] = '{"hr_inc_wrap",   4'b0010, 1'b1, 2'b10, 6'd0};
        vecs[5] = '{"next_over_inc", 4'b0110, 1'b1, 2'b01, 6'd0};
        vecs[6] = '{"next_to_sec",   4'b0100, 1'b1, 2'b00, 6'd0};
        vecs[7] = '{"next_to_hr",    4'b0100, 1'b1, 2'b10, 6'd0};
        vecs[8] = '{"next_to_min",   4'b0100, 1'b1, 2'b01, 6'd0};

        // Reset values while reset is held.
        cycles(3);
        check("rst_load", {7'd0, load}, 8'd0);
        check("rst_addrs", {6'd0, addrs}, 8'd0);
        check("rst_data", {2'd0, data_out}, 8'd0);
        check("rst_edit", {7'd0, edit_active}, 8'd0);
        check("rst_sel", {6'd0, field_sel}, 8'd2);
        check("rst_val", {2'd0, field_val}, 8'd0);
        reset = 1'b1;
        cycles(3);

        foreach (vecs[i]) begin
            press(vecs[i].btns);
            check({vecs[i].name, "_edit"}, {7'd0, edit_active}, {7'd0, vecs[i].edit});
            check({vecs[i].name, "_sel"}, {6'd0, field_sel}, {6'd0, vecs[i].sel});
            check({vecs[i].name, "_val"}, {2'd0, field_val}, {2'd0, vecs[i].val});
            check({vecs[i].name, "_load"}, {7'd0, load}, 8'd0);
        end

        // Minutes: climb to the maximum, wrap, then set 34.
        press_n(4'b0010, 59);
        check("min_at_59", {2'd0, field_val}, 8'd59);
        press(4'b0010);
        check("min_wrap_0", {2'd0, field_val}, 8'd0);
        press_n(4'b0010, 34);
        check("min_34", {2'd0, field_val}, 8'd34);

        // Seconds: wrap downward, then settle on 56.
        press(4'b0100);
        check("sel_sec", {6'd0, field_sel}, 8'd0);
        press(4'b0001);
        check("sec_dec_wrap", {2'd0, field_val}, 8'd59);
        press_n(4'b0001, 3);
        check("sec_56", {2'd0, field_val}, 8'd56);

        // Hours: a bouncing inc must be rejected, a clean hold accepted once.
        press(4'b0100);
        check("sel_hr", {6'd0, field_sel}, 8'd2);
        for (int i = 0; i < 10; i++) begin
            btn_inc = ~btn_inc;
            cycles(2);
        end
        btn_inc = 1'b0;
        cycles(12);
        check("bounce_reject", {2'd0, field_val}, 8'd0);
        btn_inc = 1'b1;
        cycles(10);
        btn_inc = 1'b0;
        cycles(10);
        check("clean_hold", {2'd0, field_val}, 8'd1);
        press_n(4'b0010, 11);
        check("hr_12", {2'd0, field_val}, 8'd12);

        // Commit burst, with an inc press timed to land inside it.
        lc = 0; first = -1; last = -1;
        btn_set = 1'b1;
        cycles(1);
        btn_inc = 1'b1;
        for (int c = 0; c < 30; c++) begin
            cycles(1);
            if (load) begin
                if (lc < 3) begin
                    la[lc] = addrs;
                    ld[lc] = data_out;
                end
                if (first < 0) first = c;
                last = c;
                lc++;
            end
        end
        drive(4'b0000);
        cycles(10);
        check("burst_count", 8'(lc), 8'd3);
        check("burst_span", 8'(last - first), 8'd2);
        if (lc >= 3) begin
            check("wr0_addr", {6'd0, la[0]}, 8'd2);
            check("wr0_data", {2'd0, ld[0]}, 8'd12);
            check("wr1_addr", {6'd0, la[1]}, 8'd1);
            check("wr1_data", {2'd0, ld[1]}, 8'd34);
            check("wr2_addr", {6'd0, la[2]}, 8'd0);
            check("wr2_data", {2'd0, ld[2]}, 8'd56);
        end
        check("post_load", {7'd0, load}, 8'd0);
        check("post_edit", {7'd0, edit_active}, 8'd0);
        check("post_hold_addr", {6'd0, addrs}, 8'd0);
        check("post_hold_data", {2'd0, data_out}, 8'd56);
        check("burst_inc_ignored", {2'd0, field_val}, 8'd12);

        // Reset asserted in the middle of a burst.
        press(4'b1000);
        check("reedit", {7'd0, edit_active}, 8'd1);
        btn_set = 1'b1;
        k = 0;
        while (!load && k < 30) begin
            cycles(1);
            k++;
        end
        check("burst2_seen", {7'd0, load}, 8'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_load", {7'd0, load}, 8'd0);
        check("midrst_edit", {7'd0, edit_active}, 8'd0);
        check("midrst_sel", {6'd0, field_sel}, 8'd2);
        check("midrst_val", {2'd0, field_val}, 8'd0);
        check("midrst_data", {2'd0, data_out}, 8'd0);
        btn_set = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(20);
        check("after_rst_load", {7'd0, load}, 8'd0);
        check("after_rst_edit", {7'd0, edit_active}, 8'd0);
        check("after_rst_val", {2'd0, field_val}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
